// File: rtl/alu_issue_stage.sv
// alu_issue_stage: decodes RV32 ALU-class instructions and presents them to the ALU from a two-entry output/skid buffer
module alu_issue_stage #(
  parameter int CNT_W  = 16,
  parameter bit EN_LUI = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [31:0]      rs1_data,
  input  logic [31:0]      rs2_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       alu_func,
  output logic [31:0]      alu_op1,
  output logic [31:0]      alu_op2,
  output logic [4:0]       rd_addr,
  output logic             rd_we,
  output logic             illegal,
  output logic [CNT_W-1:0] illegal_count
);
  typedef struct packed {
    logic [2:0]  func;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [4:0]  rd;
    logic        we;
    logic        ill;
  } bundle_t;

  bundle_t dec, out_q, out_d, skid_q, skid_d;
  logic out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [6:0] opc, f7;
  logic [2:0] f3, f3_func;
  logic is_op, is_opi, is_lui, ok_f3, legal, acc, free;
  logic unused_rs1_addr;

  assign opc = instr[6:0];
  assign f3 = instr[14:12];
  assign f7 = instr[31:25];
  assign is_op = opc == 7'b0110011;
  assign is_opi = opc == 7'b0010011;
  assign is_lui = opc == 7'b0110111;
  assign ok_f3 = f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b101 || f3[2:1] == 2'b11;
  assign f3_func = f3 == 3'b111 ? 3'b010 : f3 == 3'b110 ? 3'b011 : f3 == 3'b001 ? 3'b100 :
                   f3 == 3'b101 ? (f7[5] ? 3'b110 : 3'b101) : {2'b00, f7[5]};
  assign unused_rs1_addr = ^instr[19:15];
  assign acc = in_valid && in_ready && !flush;
  assign free = !out_valid_q || out_ready;

  // decode the offered instruction; illegal encodings carry only rd and the illegal flag
  always_comb begin
    dec = '0;
    legal = is_op  ? (f7 == 7'h00 && ok_f3) || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101)) :
            is_opi ? f3 == 3'b000 || f3[2:1] == 2'b11 || (f3 == 3'b001 && f7 == 7'h00) ||
                     (f3 == 3'b101 && (f7 == 7'h00 || f7 == 7'h20)) :
            is_lui && EN_LUI;
    dec.func = (!legal || is_lui || (is_opi && f3 == 3'b000)) ? 3'b000 : f3_func;
    dec.op1 = (legal && !is_lui) ? rs1_data : 32'd0;
    dec.op2 = !legal ? 32'd0 : is_op ? rs2_data : is_lui ? {instr[31:12], 12'b0} :
              (f3 == 3'b001 || f3 == 3'b101) ? {27'b0, instr[24:20]} : {{20{instr[31]}}, instr[31:20]};
    dec.rd = instr[11:7];
    dec.we = legal && instr[11:7] != 5'd0;
    dec.ill = !legal;
  end

  // output/skid buffer steering and saturating illegal counter
  always_comb begin
    out_d = out_q;
    skid_d = skid_q;
    out_valid_d = out_valid_q;
    skid_valid_d = skid_valid_q;
    cnt_d = (acc && dec.ill && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
    if (flush) begin
      out_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (free) begin
      out_valid_d = skid_valid_q || acc;
      out_d = skid_valid_q ? skid_q : acc ? dec : out_q;
      skid_valid_d = 1'b0;
    end else if (acc) begin
      skid_d = dec;
      skid_valid_d = 1'b1;
    end
  end

  // state registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
      skid_q <= '0;
      out_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      out_q <= out_d;
      skid_q <= skid_d;
      out_valid_q <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      cnt_q <= cnt_d;
    end
  end

  assign in_ready = !skid_valid_q;
  assign out_valid = out_valid_q;
  assign alu_func = out_q.func;
  assign alu_op1 = out_q.op1;
  assign alu_op2 = out_q.op2;
  assign rd_addr = out_q.rd;
  assign rd_we = out_q.we;
  assign illegal = out_q.ill;
  assign illegal_count = cnt_q;
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed plus random checks of alu_issue_stage against an instruction-table FIFO model
module tb_alu_issue_stage;
  localparam int CNT_W = 4;
  localparam int CMAX = 15;
  localparam logic [31:0] ADD_X3 = 32'h002081B3, SRAI = 32'h40435293, ADDI_M1 = 32'hFFF00093,
    LUI_X2 = 32'h12345137, XOR_X4 = 32'h0020C233, SUB_X0 = 32'h40208033,
    ADD_X1 = 32'h002080B3, ADD_X2 = 32'h00208133;

  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic [31:0] instr = '0, rs1_data = '0, rs2_data = '0;
  logic in_ready, out_valid, rd_we, illegal;
  logic [2:0] alu_func;
  logic [31:0] alu_op1, alu_op2;
  logic [4:0] rd_addr;
  logic [CNT_W-1:0] illegal_count;

  typedef struct packed {
    logic [2:0]  func;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [4:0]  rd;
    logic        we;
    logic        ill;
  } exp_t;

  logic [31:0] mk [14] = '{32'hFE00707F, 32'hFE00707F, 32'hFE00707F, 32'hFE00707F, 32'hFE00707F,
    32'hFE00707F, 32'hFE00707F, 32'h0000707F, 32'h0000707F, 32'h0000707F, 32'hFE00707F,
    32'hFE00707F, 32'hFE00707F, 32'h0000007F};
  logic [31:0] mt [14] = '{32'h00000033, 32'h40000033, 32'h00007033, 32'h00006033, 32'h00001033,
    32'h00005033, 32'h40005033, 32'h00000013, 32'h00007013, 32'h00006013, 32'h00001013,
    32'h00005013, 32'h40005013, 32'h00000037};
  logic [2:0] fn [14] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd0, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd0};
  int kind [14] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 2, 2, 2, 3};

  exp_t q[$];
  int cnt_m = 0;
  int checks = 0;
  int errors = 0;

  alu_issue_stage #(.CNT_W(CNT_W), .EN_LUI(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .alu_func(alu_func), .alu_op1(alu_op1), .alu_op2(alu_op2),
    .rd_addr(rd_addr), .rd_we(rd_we), .illegal(illegal), .illegal_count(illegal_count)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [31:0] i, input logic [31:0] r1, input logic [31:0] r2);
    exp_t e;
    e = '{func: 3'd0, op1: 32'd0, op2: 32'd0, rd: i[11:7], we: 1'b0, ill: 1'b1};
    for (int k = 0; k < 14; k++)
      if ((i & mk[k]) == mt[k]) begin
        e.ill = 1'b0;
        e.we = i[11:7] != 5'd0;
        e.func = fn[k];
        e.op1 = kind[k] == 3 ? 32'd0 : r1;
        e.op2 = kind[k] == 0 ? r2 : kind[k] == 1 ? 32'($signed(i[31:20])) :
                kind[k] == 2 ? 32'(i[24:20]) : (i & 32'hFFFFF000);
      end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    logic acc, drain;
    exp_t e;
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
    chk("illegal_count", 32'(illegal_count), 32'(cnt_m));
    if (q.size() != 0) begin
      chk("alu_func", 32'(alu_func), 32'(q[0].func));
      chk("alu_op1", alu_op1, q[0].op1);
      chk("alu_op2", alu_op2, q[0].op2);
      chk("rd_addr", 32'(rd_addr), 32'(q[0].rd));
      chk("rd_we", 32'(rd_we), 32'(q[0].we));
      chk("illegal", 32'(illegal), 32'(q[0].ill));
    end
    e = model(instr, rs1_data, rs2_data);
    acc = in_valid && q.size() < 2 && !flush;
    drain = q.size() != 0 && out_ready;
    @(posedge clk);
    if (flush) q.delete();
    else begin
      if (drain) void'(q.pop_front());
      if (acc) begin
        q.push_back(e);
        if (e.ill && cnt_m < CMAX) cnt_m++;
      end
    end
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [31:0] i, input logic [31:0] r1, input logic [31:0] r2,
                       input logic ordy, input logic fl);
    in_valid = v;
    instr = i;
    rs1_data = r1;
    rs2_data = r2;
    out_ready = ordy;
    flush = fl;
    cycle();
  endtask

  initial begin
    #3;
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst in_ready", 32'(in_ready), 32'd1);
    chk("rst alu_op1", alu_op1, 32'd0);
    chk("rst illegal_count", 32'(illegal_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, ADD_X3, 32'd5, 32'd7, 1, 0);
    chk("add valid", 32'(out_valid), 32'd1);
    chk("add func", 32'(alu_func), 32'd0);
    chk("add op1", alu_op1, 32'd5);
    chk("add op2", alu_op2, 32'd7);
    chk("add rd", 32'(rd_addr), 32'd3);
    chk("add we", 32'(rd_we), 32'd1);
    drive(1, SRAI, 32'h80000000, 32'd0, 1, 0);
    chk("srai func", 32'(alu_func), 32'd6);
    chk("srai op2", alu_op2, 32'd4);
    chk("srai we", 32'(rd_we), 32'd1);
    drive(1, ADDI_M1, 32'd0, 32'd0, 1, 0);
    chk("addi func", 32'(alu_func), 32'd0);
    chk("addi op2", alu_op2, 32'hFFFFFFFF);
    drive(1, LUI_X2, 32'hDEADBEEF, 32'd0, 1, 0);
    chk("lui op1", alu_op1, 32'd0);
    chk("lui op2", alu_op2, 32'h12345000);
    drive(0, 32'd0, 32'd0, 32'd0, 1, 0);
    drive(1, XOR_X4, 32'd1, 32'd2, 1, 0);
    chk("xor illegal", 32'(illegal), 32'd1);
    chk("xor we", 32'(rd_we), 32'd0);
    chk("xor count", 32'(illegal_count), 32'd1);
    drive(1, SUB_X0, 32'd9, 32'd4, 1, 0);
    chk("sub func", 32'(alu_func), 32'd1);
    chk("sub we", 32'(rd_we), 32'd0);
    chk("sub illegal", 32'(illegal), 32'd0);
    drive(0, 32'd0, 32'd0, 32'd0, 1, 0);
    drive(1, ADD_X1, 32'd1, 32'd1, 0, 0);
    drive(1, ADD_X2, 32'd2, 32'd2, 0, 0);
    drive(1, ADD_X3, 32'd3, 32'd3, 0, 0);
    chk("bp in_ready", 32'(in_ready), 32'd0);
    chk("bp first rd", 32'(rd_addr), 32'd1);
    drive(1, ADD_X3, 32'd3, 32'd3, 1, 0);
    chk("bp second rd", 32'(rd_addr), 32'd2);
    drive(1, ADD_X3, 32'd3, 32'd3, 1, 0);
    chk("bp third rd", 32'(rd_addr), 32'd3);
    drive(0, 32'd0, 32'd0, 32'd0, 1, 0);
    chk("bp drained", 32'(out_valid), 32'd0);
    drive(1, ADD_X1, 32'd1, 32'd1, 0, 0);
    drive(1, ADD_X2, 32'd2, 32'd2, 0, 0);
    drive(1, XOR_X4, 32'd0, 32'd0, 0, 1);
    chk("flush valid", 32'(out_valid), 32'd0);
    chk("flush in_ready", 32'(in_ready), 32'd1);
    drive(1, ADD_X1, 32'd1, 32'd1, 0, 0);
    drive(1, XOR_X4, 32'd0, 32'd0, 0, 1);
    chk("flush drop valid", 32'(out_valid), 32'd0);
    chk("flush drop count", 32'(illegal_count), 32'd1);
    drive(0, 32'd0, 32'd0, 32'd0, 1, 0);
    chk("flush nothing appears", 32'(out_valid), 32'd0);
    drive(1, ADD_X1, 32'd11, 32'd12, 0, 0);
    drive(1, ADD_X2, 32'd13, 32'd14, 0, 0);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("arst out_valid", 32'(out_valid), 32'd0);
    chk("arst in_ready", 32'(in_ready), 32'd1);
    chk("arst op1", alu_op1, 32'd0);
    chk("arst op2", alu_op2, 32'd0);
    chk("arst rd", 32'(rd_addr), 32'd0);
    chk("arst we", 32'(rd_we), 32'd0);
    chk("arst count", 32'(illegal_count), 32'd0);
    q.delete();
    cnt_m = 0;
    #2 rst_n = 1'b1;
    for (int n = 0; n < 400; n++) begin
      logic [31:0] w;
      int k;
      w = $urandom;
      k = $urandom_range(13);
      if ($urandom_range(3) != 0) w = (w & ~mk[k]) | mt[k];
      drive($urandom_range(3) != 0, w, $urandom, $urandom, $urandom_range(2) != 0, $urandom_range(15) == 0);
    end
    drive(0, 32'd0, 32'd0, 32'd0, 1, 0);
    drive(0, 32'd0, 32'd0, 32'd0, 1, 0);
    drive(0, 32'd0, 32'd0, 32'd0, 1, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Decode/issue stage that drives the ALU's `func`/`operand_1`/`operand_2` interface.
- Accepts raw RV32 instruction words plus register-file read data over a valid/ready handshake.
- Decodes ALU-class instructions into the 3-bit ALU function code and operands.
- Presents them from a registered two-entry (output + skid) buffer, so full throughput is held under backpressure.

Parameters:
- CNT_W, 16, width of the saturating illegal-instruction counter.
- EN_LUI, 1, when 1 LUI decodes as ADD(0, imm); when 0 LUI is illegal.

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  instruction/operand bundle valid
- in_ready  out  1  stage can accept; equals NOT skid_valid (register-derived, no comb path from out_ready)
- instr  in  32  instruction word
- rs1_data  in  32  register file read data for instr[19:15], same cycle as instr
- rs2_data  in  32  register file read data for instr[24:20], same cycle as instr
- flush  in  1  synchronous kill of all buffered entries
- out_valid  out  1  ALU bundle valid
- out_ready  in  1  ALU/writeback accepts bundle
- alu_func  out  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 SLL, 101 SRL, 110 SRA; 111 never driven
- alu_op1  out  32  ALU operand_1
- alu_op2  out  32  ALU operand_2
- rd_addr  out  5  destination register
- rd_we  out  1  write enable; 1 only for legal instr with rd != 0
- illegal  out  1  bundle is an undecodable instruction
- illegal_count  out  CNT_W  saturating count of accepted illegal instructions

Behaviour:
- Reset (rst_n low, async): out_valid=0, skid_valid=0, alu_func=000, alu_op1/op2=0, rd_addr=0, rd_we=0, illegal=0, illegal_count=0. in_ready=1 while in reset and after release.
- Accept on in_valid & in_ready. Decode is combinational on input and captured at acceptance; latency 1 cycle from accept to out_valid.
- Decode, opcode 0110011 (OP), funct7/funct3:
  - 0000000/000 ADD; 0100000/000 SUB
  - 0000000/111 AND; 0000000/110 OR
  - 0000000/001 SLL; 0000000/101 SRL; 0100000/101 SRA
  - op1=rs1_data, op2=rs2_data.
- Decode, opcode 0010011 (OP-IMM):
  - funct3 000 ADDI, 111 ANDI, 110 ORI; op2 = sign-extended instr[31:20].
  - funct3 001 SLLI requires instr[31:25]=0000000.
  - funct3 101 with instr[31:25]=0000000 SRLI, =0100000 SRAI.
  - Shifts: op2 = {27'b0, instr[24:20]}. op1=rs1_data.
- Decode, opcode 0110111 (LUI, EN_LUI=1): ADD, op1=0, op2={instr[31:12],12'b0}.
- All other encodings (XOR, SLT, SLTU, other opcodes, bad funct7):
  - illegal=1, alu_func=000, op1=op2=0, rd_addr=instr[11:7], rd_we=0.
  - illegal_count increments by 1 at acceptance and saturates at all-ones.
- Buffering:
  - Output register holds the presented bundle.
  - If out_valid & !out_ready and a new bundle is accepted, it goes to skid. in_ready drops the next cycle.
  - When the output drains and skid is valid, skid moves to output on that edge; skid_valid=0 and in_ready=1 the following cycle.
  - Simultaneous accept and drain with an empty skid: the new bundle loads output directly; out_valid stays 1; no bubble.
  - Presented bundle and all output fields are stable while out_valid & !out_ready.
  - Order is strictly FIFO.
- Flush (sync, highest priority over accept/drain):
  - Next cycle out_valid=0 and skid_valid=0.
  - A bundle offered in the flush cycle is dropped and does not count toward illegal_count.
  - illegal_count is not cleared by flush.
- Reset mid-operation discards both entries immediately; no partial bundle is ever presented.

Test Plan:
- `ADD x3,x1,x2`, rs1=5, rs2=7, out_ready=1 -> next cycle out_valid=1, func=000, op1=5, op2=7, rd_addr=3, rd_we=1.
- `SRAI x5,x6,4` (0x40435293), rs1=0x80000000 -> func=110, op2=4, rd_we=1.
- `ADDI x1,x0,-1` (0xFFF00093) -> func=000, op2=0xFFFFFFFF. `LUI x2,0x12345` -> op1=0, op2=0x12345000.
- Hold out_ready=0, offer 3 back-to-back bundles -> first two accepted, in_ready=0 on third. Release out_ready -> the three bundles emerge in order with no duplication or loss.
- Offer `XOR` (funct3 100) and `SUB x0,x1,x2` -> XOR gives illegal=1, rd_we=0, illegal_count=1; SUB gives func=001, rd_we=0, illegal=0.
- Two entries buffered, assert flush -> out_valid=0 and in_ready=1 next cycle. A bundle offered during flush never appears. Assert rst_n=0 mid-stream -> all outputs zero asynchronously.
